parallel_to_serial: RTL and testbench

Return-path counterpart of the host byte-stream loader. On a start pulse it reads a block of DBITS-wide result words from the RSA operand memory and emits them as a byte stream to the UART transmitter. Each word is sent MSB byte first, matching the loader's byte order. It sits between the modexp core's result RAM and the UART TX, handshaking with tx_ready.

---
 rtl/rsa_io_pkg.sv | 23 ++
 rtl/word_byte_shifter.sv | 53 +++++
 rtl/parallel_to_serial.sv | 130 +++++++++++++
 tb/tb_parallel_to_serial.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_io_pkg.sv
// Shared definitions for the RSA host I/O byte paths (loader and result sender).
// Byte order on the host link is MSB first for both directions.
package rsa_io_pkg;

    localparam int DBITS_DEFAULT  = 32;
    localparam int BYTES_PER_WORD = DBITS_DEFAULT / 8;

    // Host byte order: the most significant byte of a word travels first.
    localparam bit MSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        SEND    = 3'd3,
        FIN     = 3'd4
    } state_e;

    function automatic int bytes_per_word(input int dbits);
        return dbits / 8;
    endfunction

endpackage

// File: rtl/word_byte_shifter.sv
// Splits a loaded word into bytes in host order, advancing one byte per accept.
// last_o flags that the byte currently presented is the final one of the word.
module word_byte_shifter
    import rsa_io_pkg::*;
#(
    parameter int DBITS = DBITS_DEFAULT,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [DBITS-1:0] data_i,
    input  logic             accept_i,
    output logic [7:0]       byte_o,
    output logic             last_o
);

    localparam int             BPW      = bytes_per_word(DBITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BPW - 1);

    logic [DBITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = '0;
        end else if (accept_i) begin
            if (MSB_FIRST) begin
                shift_d = {shift_q[DBITS-9:0], 8'h00};
            end else begin
                shift_d = {8'h00, shift_q[DBITS-1:8]};
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_o = MSB_FIRST ? shift_q[DBITS-1 -: 8] : shift_q[7:0];
    assign last_o = (cnt_q == LAST_IDX);

endmodule

// File: rtl/parallel_to_serial.sv
// Reads a block of result words from the operand RAM and streams them to the
// UART TX one byte at a time, MSB byte of each word first.
module parallel_to_serial
    import rsa_io_pkg::*;
#(
    parameter int DBITS    = DBITS_DEFAULT,
    parameter int ABITS    = 8,
    parameter int BPW_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ABITS-1:0] base_addr,
    input  logic [ABITS-1:0] num_words,
    output logic             rd_en,
    output logic [ABITS-1:0] rd_addr,
    input  logic [DBITS-1:0] rd_data,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    // Handshake: a byte moves on any edge where tx_valid and tx_ready are both
    // high; while tx_ready is low, tx_byte and tx_valid hold their values.

    state_e state_q, state_d;

    logic [ABITS-1:0] addr_q, addr_d;
    logic [ABITS-1:0] rem_q, rem_d;

    logic rd_en_q, rd_en_d;
    logic tx_valid_q, tx_valid_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic accept;
    logic last_byte;
    logic load_word;
    logic word_end;

    assign accept    = tx_valid_q & tx_ready;
    assign load_word = (state_q == RD_WAIT);
    assign word_end  = (state_q == SEND) & accept & last_byte;

    word_byte_shifter #(
        .DBITS (DBITS),
        .CNT_W (BPW_LOG2)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_word),
        .data_i   (rd_data),
        .accept_i (accept),
        .byte_o   (tx_byte),
        .last_o   (last_byte)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            rd_en_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rd_en_q    <= rd_en_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_words == '0) ? FIN : RD_REQ;
                end
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: state_d = SEND;
            SEND: begin
                if (word_end) begin
                    state_d = (rem_q == ABITS'(1)) ? FIN : RD_REQ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address wraps naturally modulo 2^ABITS.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if ((state_q == IDLE) && start) begin
            addr_d = base_addr;
            rem_d  = num_words;
        end else if (word_end) begin
            rem_d = rem_q - ABITS'(1);
            if (rem_q != ABITS'(1)) begin
                addr_d = addr_q + ABITS'(1);
            end
        end
    end

    // done follows the FIN cycle, so busy is already low when done is seen.
    always_comb begin
        rd_en_d    = (state_d == RD_REQ);
        tx_valid_d = (state_d == SEND);
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == FIN);
    end

    assign rd_en    = rd_en_q;
    assign rd_addr  = addr_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: RAM model, scoreboard queues for bytes
// and read addresses, monitor at the falling edge, summary at the end.
module tb_parallel_to_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic [7:0]  num_words = 8'h00;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data = 32'h0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    parallel_to_serial #(
        .DBITS    (32),
        .ABITS    (8),
        .BPW_LOG2 (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data one cycle after rd_en.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Scoreboard state.
    logic [7:0] exp_q[$];
    logic [7:0] addr_q[$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_cnt = 0;
    int start_cyc = 0;
    int first_rd = -1;
    int first_valid = -1;
    int stall_from = 0;
    int stall_len = 0;
    logic stalled_prev = 1'b0;
    logic [7:0] held_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // tx_ready driver: low for stall_len cycles starting stall_from cycles after start.
    initial begin
        int rel;
        forever begin
            @(posedge clk);
            #2;
            rel = cyc - start_cyc;
            tx_ready = !(stall_len > 0 && rel >= stall_from && rel < stall_from + stall_len);
        end
    end

    // Monitor.
    always @(negedge clk) begin
        if (stalled_prev) begin
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_byte", 32'(tx_byte), 32'(held_byte));
        end
        stalled_prev = !rst && tx_valid && !tx_ready;
        held_byte = (exp_q.size() > 0) ? exp_q[0] : 8'h00;

        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'(tx_byte), 32'hFFFF_FFFF);
            end else begin
                check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
            end
        end
        if (!rst && rd_en) begin
            if (addr_q.size() == 0) begin
                check("unexpected_rd", 32'(rd_addr), 32'hFFFF_FFFF);
            end else begin
                check("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
            end
        end
        if (tx_valid && first_valid < 0) first_valid = cyc - start_cyc;
        if (rd_en && first_rd < 0) first_rd = cyc - start_cyc;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Driver: queue expectations, pulse start, then check timing and counts.
    task automatic run_xfer(input logic [7:0] base, input logic [7:0] n, input int stall);
        int d;
        int dc0;
        logic [31:0] w;
        logic [7:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = base + 8'(i);
            w = mem[a];
            addr_q.push_back(a);
            for (int b = 0; b < 4; b++) exp_q.push_back(w[31 - 8*b -: 8]);
        end
        d = 6 * int'(n) + 1 + stall;
        @(posedge clk);
        #1;
        busy_cnt = 0;
        first_valid = -1;
        first_rd = -1;
        dc0 = done_cnt;
        start_cyc = cyc + 1;
        start = 1'b1;
        base_addr = base;
        num_words = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int t = 0; t < d + 20 && done_cnt == dc0; t++) @(negedge clk);
        check("done_seen", 32'(done_cnt != dc0), 32'd1);
        check("done_latency", 32'(done_cyc - start_cyc), 32'(d));
        check("busy_cycles", 32'(busy_cnt), 32'(d));
        check("busy_after", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("done_pulses", 32'(done_cnt - dc0), 32'd1);
        check("bytes_left", 32'(exp_q.size()), 32'd0);
        check("reads_left", 32'(addr_q.size()), 32'd0);
        if (n != 8'd0) begin
            check("first_rd_lat", 32'(first_rd), 32'd0);
            check("first_valid_lat", 32'(first_valid), 32'd2);
        end else begin
            check("no_rd", 32'(first_rd), 32'hFFFF_FFFF);
            check("no_valid", 32'(first_valid), 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int dc0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]    = 32'hDEADBEEF;
        mem[0]    = 32'h01020304;
        mem[1]    = 32'hA0B0C0D0;
        mem[8'hFF] = 32'hCAFEF00D;
        mem[8]    = 32'h11223344;
        mem[9]    = 32'h55667788;
        mem[8'h30] = 32'h9ABCDEF0;
        mem[8'h20] = 32'h77777777;

        // Reset values.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word, then two words, then a stalled single word.
        run_xfer(8'd4, 8'd1, 0);
        run_xfer(8'd0, 8'd2, 0);
        stall_from = 3;
        stall_len = 5;
        run_xfer(8'd4, 8'd1, 5);
        stall_len = 0;

        // Empty block and address wrap.
        run_xfer(8'd0, 8'd0, 0);
        run_xfer(8'hFF, 8'd2, 0);

        // Reset while the second byte of a two-word block is on the line.
        for (int i = 8; i < 10; i++) begin
            addr_q.push_back(8'(i));
            for (int b = 0; b < 4; b++) exp_q.push_back(mem[i][31 - 8*b -: 8]);
        end
        @(posedge clk);
        #1;
        dc0 = done_cnt;
        start_cyc = cyc + 1;
        start = 1'b1;
        base_addr = 8'd8;
        num_words = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_en", 32'(rd_en), 32'd0);
        check("abort_bytes_left", 32'(exp_q.size()), 32'd7);
        check("abort_reads_left", 32'(addr_q.size()), 32'd1);
        exp_q.delete();
        addr_q.delete();
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        run_xfer(8'd8, 8'd2, 0);

        // Start pulses while busy (in SEND and in FIN) are ignored.
        fork
            run_xfer(8'h30, 8'd1, 0);
            begin
                repeat (4) @(posedge clk);
                #1;
                start = 1'b1;
                base_addr = 8'h20;
                num_words = 8'd3;
                @(posedge clk);
                #1;
                start = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("ignored_idle_busy", 32'(busy), 32'd0);
        check("ignored_no_bytes", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
